ex_branch_resolve: RTL and testbench
====================================

// Module: ex_branch_resolve
// PURPOSE
//  Stage directly downstream of the 64-bit ALU in the pipelined core. It consumes the ALU Result/zero
//  outputs, resolves conditional branches, and registers the EX/MEM payload. It owns the 2-bit
//  saturating-counter branch history table (BHT) read by fetch and updated at resolution. On a
//  mispredict it issues a one-cycle fetch redirect and squashes the wrong-path instruction behind it.
// PARAMETERS
//  IDX_W   6   BHT index width; the table has 2**IDX_W entries, indexed by pc[IDX_W+1:2]
//  CNT_W   32  width of the branch and mispredict statistics counters
// PORTS
//  clk            in   1      clock; all state updates on the rising edge
//  reset          in   1      synchronous, active-high reset
//  stall          in   1      pipeline hold: all state frozen while high
//  ex_valid       in   1      EX stage holds a valid instruction
//  ex_branch      in   1      EX instruction is a conditional branch
//  ex_br_type     in   2      00 BEQ, 01 BNE, 10 BLT, 11 BGE; ALU is set to a-b (ALUOp 0110)
//  ex_pc          in   64     PC of the EX instruction
//  ex_target      in   64     branch target computed in ID
//  ex_pred_taken  in   1      prediction carried down from fetch
//  alu_result     in   64     ALU Result
//  alu_zero       in   1      ALU zero flag
//  if_pc          in   64     fetch PC for BHT lookup
//  if_pred_taken  out  1      combinational: BHT[if_pc[IDX_W+1:2]][1]
//  mem_valid      out  1      registered EX/MEM valid
//  mem_alu_result out  64     registered ALU result
//  redirect       out  1      one-cycle fetch redirect / IF-ID flush
//  redirect_pc    out  64     corrected fetch PC, valid while redirect=1
//  branch_cnt     out  CNT_W  resolved branches, saturating
//  mispred_cnt    out  CNT_W  mispredicted branches, saturating
// BEHAVIOUR
//  Reset: mem_valid=0, mem_alu_result=0, redirect=0, redirect_pc=0, counters=0, all BHT entries=2'b01
//   (weakly not-taken), FSM=RUN. Reset takes priority over stall.
//  Accept: the instruction is accepted when ex_valid & ~stall & FSM==RUN.
//  Taken: BEQ=zero, BNE=~zero, BLT=alu_result[63], BGE=~alu_result[63]. Overflow is not corrected.
//  Mispredict: accept & ex_branch & (taken != ex_pred_taken).
//  Latency: one cycle. mem_* and redirect become visible the edge after accept.
//  mem_valid <= accept. mem_alu_result loads on accept and holds otherwise.
//  FSM: RUN and SQUASH.
//   RUN -> SQUASH on mispredict. The same edge sets redirect=1 and
//   redirect_pc = taken ? ex_target : ex_pc+4.
//   SQUASH: redirect=1 for exactly this cycle. ex_valid is ignored: mem_valid<=0, no BHT or
//   counter update. Returns to RUN on the next non-stalled edge, which clears redirect.
//   If stall=1 in SQUASH, the FSM and redirect hold until stall drops.
//  BHT update, on each accepted branch only: entry = pc[IDX_W+1:2].
//   taken: increments, saturating at 3. not taken: decrements, saturating at 0.
//  if_pred_taken is read before the update. There is no same-cycle bypass: when if_pc and ex_pc
//   index the same entry, the old value is returned.
//  branch_cnt +1 per accepted branch. mispred_cnt +1 per mispredict. Both saturate at all-ones.
//  Non-branch accepts touch only mem_*.
// TESTING
//  Reset, then if_pc=0x40 -> if_pred_taken=0, all outputs 0.
//  BEQ, pc=0x100, target=0x180, pred=0, zero=1 -> next cycle redirect=1 with redirect_pc=0x180;
//   mispred_cnt=1; BHT[0x100] reads 2 (predict taken).
//  BNE, pc=0x200, pred=0, zero=1 -> no redirect; BHT[0x200] goes 1->0; a second identical branch
//   leaves it at 0 (saturated).
//  Mispredict followed by a valid ALU op next cycle -> that op is squashed (mem_valid=0,
//   counters unchanged); redirect lasts 1 cycle.
//  Mispredict with stall=1 held 3 cycles in SQUASH -> redirect stays 1 for the 3 stalled cycles
//   plus 1, then 0.
//  BLT, a-b=0xFFFF_FFFF_FFFF_FFFE, pred=1 -> taken, no redirect; mem_alu_result=0xFFFF_FFFF_FFFF_FFFE.
//   Asserting reset mid-SQUASH -> redirect=0 and FSM=RUN next edge.

Source files
------------

// File: rtl/ex_branch_resolve.sv
// ex_branch_resolve
//   Sits directly behind the 64-bit ALU. Resolves conditional branches from the
//   ALU result/zero flag and registers the EX/MEM payload. It also owns the
//   2-bit saturating branch history table read by fetch. A mispredict raises a
//   one-cycle fetch redirect and squashes the wrong-path instruction behind it.
//
// Parameters
//   IDX_W  BHT index width; 2**IDX_W entries, indexed by pc[IDX_W+1:2]
//   CNT_W  width of the branch / mispredict statistics counters
//
// Ports
//   clk, reset       clock, synchronous active-high reset
//   stall            freezes all state while high
//   ex_*             EX-stage instruction: valid, branch, type, pc, target, prediction
//   alu_result/zero  ALU outputs (ALU computes a-b for branches)
//   if_pc            fetch PC for the BHT lookup
//   if_pred_taken    combinational BHT prediction for if_pc
//   mem_valid        registered EX/MEM valid
//   mem_alu_result   registered ALU result
//   redirect         one-cycle fetch redirect / IF-ID flush
//   redirect_pc      corrected fetch PC
//   branch_cnt       resolved branches (saturating)
//   mispred_cnt      mispredicted branches (saturating)
module ex_branch_resolve #(
    parameter int unsigned IDX_W = 6,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             ex_valid,
    input  logic             ex_branch,
    input  logic [1:0]       ex_br_type,
    input  logic [63:0]      ex_pc,
    input  logic [63:0]      ex_target,
    input  logic             ex_pred_taken,
    input  logic [63:0]      alu_result,
    input  logic             alu_zero,
    input  logic [63:0]      if_pc,
    output logic             if_pred_taken,
    output logic             mem_valid,
    output logic [63:0]      mem_alu_result,
    output logic             redirect,
    output logic [63:0]      redirect_pc,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    localparam int unsigned ENTRIES = 2 ** IDX_W;

    typedef enum logic {
        RUN    = 1'b0,
        SQUASH = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic [1:0]       bht [ENTRIES];
    logic [IDX_W-1:0] ex_idx;
    logic [IDX_W-1:0] if_idx;
    logic             taken;
    logic             accept;
    logic             acc_branch;
    logic             mispredict;

    assign ex_idx = ex_pc[IDX_W+1:2];
    assign if_idx = if_pc[IDX_W+1:2];

    // Read of the table before any update this cycle: no bypass from EX.
    always_comb begin
        if_pred_taken = bht[if_idx][1];
    end

    always_comb begin
        taken = 1'b0;
        case (ex_br_type)
            2'b00: taken = alu_zero;
            2'b01: taken = ~alu_zero;
            2'b10: taken = alu_result[63];
            2'b11: taken = ~alu_result[63];
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        accept     = ex_valid & ~stall & (state == RUN);
        acc_branch = accept & ex_branch;
        mispredict = acc_branch & (taken != ex_pred_taken);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (mispredict) state_nxt = SQUASH;
            SQUASH:  if (!stall)     state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // In SQUASH accept is low, so a non-stalled edge clears mem_valid and
    // redirect and leaves the table and counters untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_valid      <= 1'b0;
            mem_alu_result <= '0;
            redirect       <= 1'b0;
            redirect_pc    <= '0;
            branch_cnt     <= '0;
            mispred_cnt    <= '0;
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                bht[i] <= 2'b01;
            end
        end else if (!stall) begin
            mem_valid <= accept;
            redirect  <= mispredict;
            if (accept) begin
                mem_alu_result <= alu_result;
            end
            if (mispredict) begin
                redirect_pc <= taken ? ex_target : ex_pc + 64'd4;
                if (mispred_cnt != '1) begin
                    mispred_cnt <= mispred_cnt + CNT_W'(1);
                end
            end
            if (acc_branch) begin
                if (branch_cnt != '1) begin
                    branch_cnt <= branch_cnt + CNT_W'(1);
                end
                if (taken) begin
                    if (bht[ex_idx] != 2'b11) bht[ex_idx] <= bht[ex_idx] + 2'd1;
                end else begin
                    if (bht[ex_idx] != 2'b00) bht[ex_idx] <= bht[ex_idx] - 2'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ex_branch_resolve.sv
module tb_ex_branch_resolve;

    logic        clk = 1'b0;
    logic        reset, stall, ex_valid, ex_branch, ex_pred_taken, alu_zero;
    logic [1:0]  ex_br_type;
    logic [63:0] ex_pc, ex_target, alu_result, if_pc;
    logic        if_pred_taken, mem_valid, redirect;
    logic [63:0] mem_alu_result, redirect_pc;
    logic [31:0] branch_cnt, mispred_cnt;

    always #5 clk = ~clk;

    ex_branch_resolve #(.IDX_W(6), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .stall(stall), .ex_valid(ex_valid),
        .ex_branch(ex_branch), .ex_br_type(ex_br_type), .ex_pc(ex_pc),
        .ex_target(ex_target), .ex_pred_taken(ex_pred_taken),
        .alu_result(alu_result), .alu_zero(alu_zero), .if_pc(if_pc),
        .if_pred_taken(if_pred_taken), .mem_valid(mem_valid),
        .mem_alu_result(mem_alu_result), .redirect(redirect),
        .redirect_pc(redirect_pc), .branch_cnt(branch_cnt),
        .mispred_cnt(mispred_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    typedef struct {
        bit          valid;
        logic [63:0] res;
        bit          red;
        logic [63:0] rpc;
        longint unsigned bc;
        longint unsigned mc;
        bit          ifp;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: architectural state as plain variables.
    int              m_bht [64];
    bit              m_squash;
    bit              m_valid, m_red;
    logic [63:0]     m_res, m_rpc;
    longint unsigned m_bc, m_mc;
    localparam longint unsigned CNT_MAX = 64'hFFFF_FFFF;

    function automatic void model_reset();
        foreach (m_bht[i]) m_bht[i] = 1;
        m_squash = 0; m_valid = 0; m_red = 0;
        m_res = '0; m_rpc = '0; m_bc = 0; m_mc = 0;
    endfunction

    function automatic int idx_of(logic [63:0] pc);
        return int'((pc >> 2) % 64);
    endfunction

    // One cycle: drive inputs just after the edge, record what the DUT should
    // show now, then advance the model across the coming edge.
    task automatic cyc(input bit rst, input bit stl, input bit vld, input bit br,
                       input logic [1:0] bt, input logic [63:0] pc, input logic [63:0] tgt,
                       input bit pred, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] ipc);
        exp_t e;
        logic [63:0] r;
        bit tk;
        @(posedge clk);
        #1;
        r = a - b;
        reset = rst; stall = stl; ex_valid = vld; ex_branch = br; ex_br_type = bt;
        ex_pc = pc; ex_target = tgt; ex_pred_taken = pred;
        alu_result = r; alu_zero = (r == 0); if_pc = ipc;
        e.valid = m_valid; e.res = m_res; e.red = m_red; e.rpc = m_rpc;
        e.bc = m_bc; e.mc = m_mc; e.ifp = (m_bht[idx_of(ipc)] >= 2);
        exp_q.push_back(e);
        if (rst) begin
            model_reset();
        end else if (stl) begin
            // everything holds
        end else if (m_squash) begin
            m_squash = 0; m_valid = 0; m_red = 0;
        end else begin
            m_valid = vld;
            m_red = 0;
            if (vld) m_res = r;
            if (vld && br) begin
                case (bt)
                    2'd0: tk = (a == b);
                    2'd1: tk = (a != b);
                    2'd2: tk = r[63];
                    default: tk = !r[63];
                endcase
                if (tk) m_bht[idx_of(pc)] = (m_bht[idx_of(pc)] == 3) ? 3 : m_bht[idx_of(pc)] + 1;
                else    m_bht[idx_of(pc)] = (m_bht[idx_of(pc)] == 0) ? 0 : m_bht[idx_of(pc)] - 1;
                if (m_bc < CNT_MAX) m_bc++;
                if (tk != pred) begin
                    if (m_mc < CNT_MAX) m_mc++;
                    m_red = 1; m_squash = 1;
                    m_rpc = tk ? tgt : pc + 64'd4;
                end
            end
        end
    endtask

    task automatic idle(input logic [63:0] ipc);
        cyc(0, 0, 0, 0, 2'd0, 64'h0, 64'h0, 0, 64'd0, 64'd0, ipc);
    endtask

    task automatic alu_op(input logic [63:0] a, input logic [63:0] b);
        cyc(0, 0, 1, 0, 2'd0, 64'h300, 64'h0, 0, a, b, 64'h40);
    endtask

    // Monitor: one expected record per cycle, compared mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("mem_valid",      {63'd0, mem_valid},     {63'd0, e.valid});
            chk("mem_alu_result", mem_alu_result,         e.res);
            chk("redirect",       {63'd0, redirect},      {63'd0, e.red});
            if (e.red) chk("redirect_pc", redirect_pc,    e.rpc);
            chk("branch_cnt",     {32'd0, branch_cnt},    e.bc);
            chk("mispred_cnt",    {32'd0, mispred_cnt},   e.mc);
            chk("if_pred_taken",  {63'd0, if_pred_taken}, {63'd0, e.ifp});
        end
    end

    initial begin
        logic [63:0] pcs [8];
        logic [63:0] a, b;
        int wait_cnt;
        pcs = '{64'h100, 64'h104, 64'h200, 64'h204, 64'h300, 64'h400, 64'h1F8, 64'h0};

        reset = 1; stall = 0; ex_valid = 0; ex_branch = 0; ex_br_type = 0;
        ex_pc = 0; ex_target = 0; ex_pred_taken = 0; alu_result = 0; alu_zero = 0;
        if_pc = 64'h40;
        repeat (2) @(posedge clk);
        model_reset();

        // reset state
        cyc(1, 1, 1, 1, 2'd0, 64'h100, 64'h180, 0, 64'd5, 64'd5, 64'h40);
        idle(64'h40);
        #1;
        chk("reset_if_pred", {63'd0, if_pred_taken}, 64'd0);
        chk("reset_mem_valid", {63'd0, mem_valid}, 64'd0);
        chk("reset_redirect", {63'd0, redirect}, 64'd0);

        // BEQ mispredict, then an ALU op that must be squashed
        cyc(0, 0, 1, 1, 2'd0, 64'h100, 64'h180, 0, 64'd7, 64'd7, 64'h40);
        alu_op(64'd50, 64'd8);
        #1;
        chk("beq_redirect", {63'd0, redirect}, 64'd1);
        chk("beq_redirect_pc", redirect_pc, 64'h180);
        chk("beq_mispred_cnt", {32'd0, mispred_cnt}, 64'd1);
        idle(64'h100);
        #1;
        chk("squash_mem_valid", {63'd0, mem_valid}, 64'd0);
        chk("squash_redirect_drop", {63'd0, redirect}, 64'd0);
        chk("squash_branch_cnt", {32'd0, branch_cnt}, 64'd1);
        chk("bht_0x100_taken", {63'd0, if_pred_taken}, 64'd1);

        // BNE not taken, predicted not taken, twice (saturate at 0)
        cyc(0, 0, 1, 1, 2'd1, 64'h200, 64'h280, 0, 64'd3, 64'd3, 64'h200);
        cyc(0, 0, 1, 1, 2'd1, 64'h200, 64'h280, 0, 64'd3, 64'd3, 64'h200);
        #1;
        chk("bne_no_redirect", {63'd0, redirect}, 64'd0);
        // weakly taken after one taken BNE from 0 would be 1: stays not-taken
        cyc(0, 0, 1, 1, 2'd1, 64'h200, 64'h280, 1, 64'd4, 64'd3, 64'h200);
        idle(64'h200);
        idle(64'h200);
        #1;
        chk("bne_bht_sat", {63'd0, if_pred_taken}, 64'd0);

        // Mispredict then stall held 3 cycles in SQUASH
        cyc(0, 0, 1, 1, 2'd2, 64'h104, 64'h40, 0, 64'd1, 64'd2, 64'h40);
        repeat (3) cyc(0, 1, 1, 0, 2'd0, 64'h300, 64'h0, 0, 64'd9, 64'd1, 64'h40);
        #1;
        chk("stall_redirect_held", {63'd0, redirect}, 64'd1);
        alu_op(64'd9, 64'd1);
        #1;
        chk("stall_redirect_last", {63'd0, redirect}, 64'd1);
        idle(64'h40);
        #1;
        chk("stall_redirect_clear", {63'd0, redirect}, 64'd0);

        // BLT taken with negative difference, predicted taken
        cyc(0, 0, 1, 1, 2'd2, 64'h400, 64'h500, 1, 64'd0, 64'd2, 64'h40);
        idle(64'h40);
        #1;
        chk("blt_no_redirect", {63'd0, redirect}, 64'd0);
        chk("blt_result", mem_alu_result, 64'hFFFF_FFFF_FFFF_FFFE);

        // Reset mid-SQUASH
        cyc(0, 0, 1, 1, 2'd3, 64'h1F8, 64'h20, 0, 64'd5, 64'd1, 64'h40);
        cyc(1, 1, 1, 0, 2'd0, 64'h0, 64'h0, 0, 64'd0, 64'd0, 64'h40);
        idle(64'h40);
        #1;
        chk("reset_sq_redirect", {63'd0, redirect}, 64'd0);
        alu_op(64'd20, 64'd3);
        idle(64'h40);
        #1;
        chk("reset_sq_run", {63'd0, mem_valid}, 64'd1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            a = {$urandom, $urandom};
            b = ($urandom_range(0, 3) == 0) ? a : {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) b = a - 64'($urandom_range(0, 4)) + 64'd2;
            cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 4) == 0),
                ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0),
                2'($urandom_range(0, 3)), pcs[$urandom_range(0, 7)],
                {$urandom, $urandom}, 1'($urandom_range(0, 1)), a, b,
                pcs[$urandom_range(0, 7)]);
        end
        idle(64'h40);

        wait_cnt = 0;
        while (exp_q.size() > 0 && wait_cnt < 10) begin
            @(posedge clk);
            wait_cnt++;
        end
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d records left, required 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
